// File: rtl/clos_node.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clos_node: one Clos TCDM switch stage (ingress spread or routed xbar),   |
// | combinational request path, MemLatency-delayed response return.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clos_node #(
  parameter int NumIn         = 4,
  parameter int NumOut        = 4,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32,
  parameter int WriteRespOn   = 1,
  parameter int MemLatency    = 1,
  parameter int NodeType      = 0,
  parameter int ExtPrio       = 0,
  localparam int AW = (NumOut > 1) ? $clog2(NumOut) : 1,
  localparam int IW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumIn-1:0]                     req_i,
  input  logic [NumIn-1:0][AW-1:0]             add_i,
  input  logic [NumIn-1:0]                     wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]   wdata_i,
  output logic [NumIn-1:0]                     gnt_o,
  output logic [NumIn-1:0]                     vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]  rdata_o,
  input  logic [NumOut-1:0][IW-1:0]            rr_i,
  input  logic [NumOut-1:0]                    gnt_i,
  output logic [NumOut-1:0]                    req_o,
  output logic [NumOut-1:0][ReqDataWidth-1:0]  wdata_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0] rdata_i
);

  logic [NumOut-1:0][IW-1:0]          ptr_q, ptr_d;
  logic [NumOut-1:0][IW-1:0]          start;
  logic [NumOut-1:0]                  sel_vld;
  logic [NumOut-1:0][IW-1:0]          sel_idx;
  logic [NumIn-1:0][AW-1:0]           out_idx;
  logic [NumIn-1:0]                   respond;
  logic [MemLatency-1:0][NumIn-1:0]   pg_q, pr_q;
  logic [MemLatency-1:0][NumIn-1:0][AW-1:0] pi_q;

  // Start index doubles as the ingress candidate and the routing scan origin.
  always_comb begin
    start = '0;
    for (int m = 0; m < NumOut; m++) begin
      if (NumIn > 1) start[m] = (ExtPrio != 0) ? rr_i[m] : ptr_q[m];
    end
  end

  always_comb begin
    logic dup;
    int   idx;
    int   tgt;
    sel_vld = '0;
    sel_idx = '0;
    dup     = 1'b0;
    idx     = 0;
    tgt     = 0;
    for (int m = 0; m < NumOut; m++) begin
      if (NodeType == 0) begin
        dup = 1'b0;
        for (int n = 0; n < m; n++) begin
          if (start[n] == start[m]) dup = 1'b1;
        end
        if (!dup && req_i[start[m]]) begin
          sel_vld[m] = 1'b1;
          sel_idx[m] = start[m];
        end
      end else begin
        // Downward scan with overwrite leaves the first upward hit from start.
        for (int k = NumIn - 1; k >= 0; k--) begin
          idx = (int'(start[m]) + k) % NumIn;
          tgt = (NumOut == 1) ? 0 : int'(add_i[idx]);
          if (req_i[idx] && (tgt == m)) begin
            sel_vld[m] = 1'b1;
            sel_idx[m] = IW'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < NumOut; m++) begin
      req_o[m]   = sel_vld[m];
      wdata_o[m] = sel_vld[m] ? wdata_i[sel_idx[m]] : '0;
      ptr_d[m]   = ptr_q[m];
      if ((ExtPrio == 0) && sel_vld[m] && gnt_i[m]) begin
        ptr_d[m] = IW'((int'(sel_idx[m]) + 1) % NumIn);
      end
    end
  end

  // An input is selected by at most one output, so OR-ing is unambiguous.
  always_comb begin
    gnt_o   = '0;
    out_idx = '0;
    for (int i = 0; i < NumIn; i++) begin
      for (int m = 0; m < NumOut; m++) begin
        if (sel_vld[m] && (sel_idx[m] == IW'(i))) begin
          gnt_o[i]   = gnt_i[m];
          out_idx[i] = AW'(m);
        end
      end
      respond[i] = gnt_o[i] & (~wen_i[i] | (WriteRespOn != 0));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      pg_q  <= '0;
      pr_q  <= '0;
      pi_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      pg_q[0] <= gnt_o;
      pr_q[0] <= respond;
      pi_q[0] <= out_idx;
      for (int s = 1; s < MemLatency; s++) begin
        pg_q[s] <= pg_q[s-1];
        pr_q[s] <= pr_q[s-1];
        pi_q[s] <= pi_q[s-1];
      end
    end
  end

  assign vld_o = pr_q[MemLatency-1];

  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      rdata_o[i] = pg_q[MemLatency-1][i] ? rdata_i[pi_q[MemLatency-1][i]] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clos_node.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clos_node: directed self-checking bench for clos_node.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_clos_node;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for routing instances a (WriteRespOn=1), b (=0), d (ML=2)
  logic                  rst, rst_d;
  logic [3:0]            req, wen, gnt;
  logic [3:0][1:0]       add, rr;
  logic [3:0][31:0]      wdata, rdata;
  logic [3:0]            gnt_a, vld_a, req_o_a, gnt_b, vld_b, req_o_b, gnt_d, vld_d, req_o_d;
  logic [3:0][31:0]      rdata_a, wdata_a, rdata_b, wdata_b, rdata_d, wdata_d;

  // Ingress instance c: NumIn=2, NumOut=4, ExtPrio=1
  logic [1:0]            req_c, wen_c, gnt_o_c, vld_c;
  logic [1:0][1:0]       add_c;
  logic [1:0][31:0]      wdata_c, rdata_o_c;
  logic [3:0][0:0]       rr_c;
  logic [3:0]            gnt_c, req_o_c;
  logic [3:0][31:0]      wdata_o_c, rdata_c;

  int n_cmp = 0;
  int n_err = 0;

  clos_node #(.NumIn(4), .NumOut(4), .WriteRespOn(1), .MemLatency(1), .NodeType(1), .ExtPrio(0)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_a), .rr_i(rr), .gnt_i(gnt),
    .req_o(req_o_a), .wdata_o(wdata_a), .rdata_i(rdata));

  clos_node #(.NumIn(4), .NumOut(4), .WriteRespOn(0), .MemLatency(1), .NodeType(1), .ExtPrio(0)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_b), .rr_i(rr), .gnt_i(gnt),
    .req_o(req_o_b), .wdata_o(wdata_b), .rdata_i(rdata));

  clos_node #(.NumIn(4), .NumOut(4), .WriteRespOn(1), .MemLatency(2), .NodeType(1), .ExtPrio(0)) u_d (
    .clk_i(clk), .rst_i(rst_d), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .gnt_o(gnt_d), .vld_o(vld_d), .rdata_o(rdata_d), .rr_i(rr), .gnt_i(gnt),
    .req_o(req_o_d), .wdata_o(wdata_d), .rdata_i(rdata));

  clos_node #(.NumIn(2), .NumOut(4), .WriteRespOn(1), .MemLatency(1), .NodeType(0), .ExtPrio(1)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .add_i(add_c), .wen_i(wen_c), .wdata_i(wdata_c),
    .gnt_o(gnt_o_c), .vld_o(vld_c), .rdata_o(rdata_o_c), .rr_i(rr_c), .gnt_i(gnt_c),
    .req_o(req_o_c), .wdata_o(wdata_o_c), .rdata_i(rdata_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_d = 1'b1;
    req = '0; wen = '0; gnt = '0; add = '0; rr = '0; wdata = '0; rdata = '0;
    req_c = '0; wen_c = '0; add_c = '0; wdata_c = '0; rr_c = '0; gnt_c = '0; rdata_c = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state; request path stays combinational under reset
    rdata = {4{32'hFFFF_FFFF}};
    req = 4'b0001;
    #2;
    chk("rst_vld", vld_a, 4'b0000);
    chk("rst_rdata", rdata_a[0], 32'h0);
    chk("rst_comb_req_o", req_o_a, 4'b0001);
    req = '0; rdata = '0;
    rst = 1'b0; rst_d = 1'b0;

    // Round-robin alternation on output 1
    step(); req = 4'b0101; add[0] = 2'd1; add[2] = 2'd1; gnt = 4'b1111;
    wdata[0] = 32'h100; wdata[2] = 32'h102; #2;
    chk("rr0_gnt", gnt_a, 4'b0001);
    chk("rr0_req_o", req_o_a, 4'b0010);
    chk("rr0_wdata_o", wdata_a[1], 32'h100);
    step(); rdata[1] = 32'h1111; #2;
    chk("rr1_gnt", gnt_a, 4'b0100);
    chk("rr1_wdata_o", wdata_a[1], 32'h102);
    chk("rr1_vld", vld_a, 4'b0001);
    chk("rr1_rdata0", rdata_a[0], 32'h1111);
    step(); #2;
    chk("rr2_gnt", gnt_a, 4'b0001);
    chk("rr2_vld", vld_a, 4'b0100);
    chk("rr2_rdata2", rdata_a[2], 32'h1111);
    step(); req = '0; #2;
    chk("rr3_vld", vld_a, 4'b0001);
    step(); #2;
    chk("rr4_vld", vld_a, 4'b0000);

    // Load from input 3 to output 2, response one cycle later
    step(); req = 4'b1000; add[3] = 2'd2; #2;
    chk("ld_gnt", gnt_a, 4'b1000);
    chk("ld_vld_early", vld_a, 4'b0000);
    step(); req = '0; rdata[2] = 32'hCAFE; #2;
    chk("ld_vld", vld_a, 4'b1000);
    chk("ld_rdata", rdata_a[3], 32'hCAFE);
    step(); #2;
    chk("ld_vld_end", vld_a, 4'b0000);

    // Store: response only when WriteRespOn=1
    step(); req = 4'b0010; add[1] = 2'd0; wen = 4'b0010; #2;
    chk("st_gnt_wr1", gnt_a, 4'b0010);
    chk("st_gnt_wr0", gnt_b, 4'b0010);
    step(); req = '0; wen = '0; #2;
    chk("st_vld_wr1", vld_a, 4'b0010);
    chk("st_vld_wr0", vld_b, 4'b0000);
    step(); #2;
    chk("st_vld_wr0_late", vld_b, 4'b0000);

    // Downstream refuses: no grant, no response, pointer held at 0
    step(); req = 4'b0001; add[0] = 2'd3; gnt = 4'b0111; #2;
    chk("ng_req_o", req_o_a, 4'b1001 & 4'b1000 | 4'b1000);
    chk("ng_gnt", gnt_a, 4'b0000);
    step(); req = 4'b0011; add[1] = 2'd3; gnt = 4'b1111; #2;
    chk("ng_vld", vld_a, 4'b0000);
    chk("ng_ptr_hold", gnt_a, 4'b0001);
    step(); req = '0; #2;
    chk("ng_vld_after", vld_a, 4'b0001);

    // Ingress spreading with external priority
    step(); rr_c = 4'b1010; req_c = 2'b11; gnt_c = 4'b1111;
    wdata_c[0] = 32'hAAAA_0000; wdata_c[1] = 32'h5555_0001; #2;
    chk("ing_req_o", req_o_c, 4'b0011);
    chk("ing_wdata0", wdata_o_c[0], 32'hAAAA_0000);
    chk("ing_wdata1", wdata_o_c[1], 32'h5555_0001);
    chk("ing_wdata2", wdata_o_c[2], 32'h0);
    chk("ing_wdata3", wdata_o_c[3], 32'h0);
    chk("ing_gnt", gnt_o_c, 2'b11);
    step(); rr_c = 4'b0001; rdata_c[0] = 32'h77; rdata_c[1] = 32'h88; #2;
    chk("ing_vld", vld_c, 2'b11);
    chk("ing_rdata0", rdata_o_c[0], 32'h77);
    chk("ing_rdata1", rdata_o_c[1], 32'h88);
    chk("ing_swap_wdata0", wdata_o_c[0], 32'h5555_0001);
    step(); req_c = '0; #2;
    chk("ing_swap_rdata0", rdata_o_c[0], 32'h88);

    // Reset with a response in flight (MemLatency=2)
    step(); req = 4'b0001; add[0] = 2'd0; wen = '0; rdata[0] = 32'hBEEF; #2;
    chk("rs_gnt", gnt_d, 4'b0001);
    step(); req = '0; rst_d = 1'b1; #2;
    chk("rs_vld_in_rst", vld_d, 4'b0000);
    step(); rst_d = 1'b0; #2;
    chk("rs_no_pulse", vld_d, 4'b0000);
    step(); #2;
    chk("rs_no_pulse2", vld_d, 4'b0000);
    step(); req = 4'b0001; #2;
    chk("rs2_gnt", gnt_d, 4'b0001);
    step(); req = '0; #2;
    chk("rs2_vld_early", vld_d, 4'b0000);
    step(); #2;
    chk("rs2_vld", vld_d, 4'b0001);
    chk("rs2_rdata", rdata_d[0], 32'hBEEF);
    #1 rst_d = 1'b1;
    #1;
    chk("rs2_vld_clr", vld_d, 4'b0000);
    chk("rs2_rdata_clr", rdata_d[0], 32'h0);
    step(); rst_d = 1'b0; #2;
    chk("rs2_after", vld_d, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
